// File: rtl/keypad_token_parser_pkg.sv
// Shared key codes, token encodings and parser state enumeration.
// Imported by the keypad token parser and its interface.
package keypad_pkg;

    localparam logic [3:0] KEY_D0 = 4'd0;
    localparam logic [3:0] KEY_D9 = 4'd9;
    localparam logic [3:0] KEY_S  = 4'd10;
    localparam logic [3:0] KEY_M  = 4'd11;
    localparam logic [3:0] KEY_K  = 4'd15;

    localparam logic [1:0] TOK_ID   = 2'd0;
    localparam logic [1:0] TOK_PIN  = 2'd1;
    localparam logic [1:0] TOK_MENU = 2'd2;
    localparam logic [1:0] TOK_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_PINDIR = 2'd2
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= KEY_D9;
    endfunction

endpackage

// File: rtl/keypad_token_parser_if.sv
// Keypad code stream in, token strobe and payload out.
// slave = parser side, master = keypad/controller side.
interface keypad_token_parser_if;

    logic [3:0]  key_in;
    logic        tok_valid;
    logic [1:0]  tok_type;
    logic [15:0] tok_data;

    modport slave (
        input  key_in,
        output tok_valid,
        output tok_type,
        output tok_data
    );

    modport master (
        output key_in,
        input  tok_valid,
        input  tok_type,
        input  tok_data
    );

endinterface

// File: rtl/keypad_token_parser.sv
// Frames keypad digits between S/M delimiters and emits
// one-cycle ID/PIN/MENU/ERR tokens with a BCD payload.
module keypad_token_parser
    import keypad_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_token_parser_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [15:0]   sr_q, sr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tok_valid_q, tok_valid_d;
    logic [1:0]    tok_type_q, tok_type_d;
    logic [15:0]   tok_data_q, tok_data_d;

    logic [3:0]    key;
    logic          k_dig, k_s, k_m, k_k;
    logic          emit;
    logic [1:0]    emit_type;
    logic [15:0]   emit_data;
    logic          in_frame;

    assign key   = bus.key_in;
    assign k_dig = is_digit(key);
    assign k_s   = (key == KEY_S);
    assign k_m   = (key == KEY_M);
    assign k_k   = (key == KEY_K);

    // Next-state, framing and token selection for the sampled key.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        tmo_d      = tmo_q;
        emit       = 1'b0;
        emit_type  = TOK_ERR;
        emit_data  = 16'h0000;
        in_frame   = (state_q == ST_FRAME);
        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                unique case (1'b1)
                    k_k, k_dig: ;
                    k_s: begin
                        state_d = ST_FRAME;
                        cnt_d   = 3'd0;
                        sr_d    = 16'h0000;
                    end
                    k_m: begin
                        emit      = 1'b1;
                        emit_type = TOK_MENU;
                    end
                    default: emit = 1'b1;
                endcase
            end
            default: begin
                unique case (1'b1)
                    k_k: begin
                        // Abort a frame left open with no keystrokes.
                        if (tmo_q == TW'(TIMEOUT - 1)) begin
                            emit    = 1'b1;
                            state_d = ST_IDLE;
                            tmo_d   = '0;
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                        end
                    end
                    k_dig: begin
                        tmo_d = '0;
                        if (cnt_q == 3'd4) begin
                            emit    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            sr_d  = {sr_q[11:0], key};
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                    k_s: begin
                        tmo_d   = '0;
                        emit    = 1'b1;
                        state_d = ST_IDLE;
                        if (cnt_q == 3'd4) begin
                            emit_type = TOK_PIN;
                            emit_data = sr_q;
                        end else if (in_frame && cnt_q == 3'd3) begin
                            emit_type = TOK_ID;
                            emit_data = {4'h0, sr_q[11:0]};
                        end
                    end
                    k_m: begin
                        tmo_d = '0;
                        emit  = 1'b1;
                        if (in_frame && cnt_q == 3'd3) begin
                            emit_type = TOK_ID;
                            emit_data = {4'h0, sr_q[11:0]};
                            state_d   = ST_PINDIR;
                            cnt_d     = 3'd0;
                            sr_d      = 16'h0000;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        tmo_d   = '0;
                        emit    = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end
        endcase
        tok_valid_d = emit;
        tok_type_d  = emit ? emit_type : tok_type_q;
        tok_data_d  = emit ? emit_data : tok_data_q;
    end

    // State, framing registers and registered token outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            sr_q        <= 16'h0000;
            tmo_q       <= '0;
            tok_valid_q <= 1'b0;
            tok_type_q  <= 2'd0;
            tok_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            tmo_q       <= tmo_d;
            tok_valid_q <= tok_valid_d;
            tok_type_q  <= tok_type_d;
            tok_data_q  <= tok_data_d;
        end
    end

    assign bus.tok_valid = tok_valid_q;
    assign bus.tok_type  = tok_type_q;
    assign bus.tok_data  = tok_data_q;

endmodule

// File: tb/tb_keypad_token_parser.sv
// Randomized and directed bench for keypad_token_parser,
// checked against a queue-based token model.
module tb_keypad_token_parser;

    localparam int TIMEOUT = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    keypad_token_parser_if bus ();

    keypad_token_parser #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: frame mode, collected digits, K run length.
    int mode;
    int digs[$];
    int kc;
    int m_valid;
    int m_type;
    int m_data;
    int seq[$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int bcd();
        int v = 0;
        foreach (digs[i]) v = v * 16 + digs[i];
        return v;
    endfunction

    function automatic void tok(input int t, input int d);
        m_valid = 1;
        m_type  = t;
        m_data  = d;
    endfunction

    function automatic void model_reset();
        mode = 0;
        digs.delete();
        kc = 0;
        m_valid = 0;
        m_type = 0;
        m_data = 0;
    endfunction

    function automatic void model(input int k);
        m_valid = 0;
        if (k == 15) begin
            if (mode != 0) begin
                kc++;
                if (kc == TIMEOUT) begin
                    tok(3, 0);
                    mode = 0;
                    kc = 0;
                end
            end
            return;
        end
        kc = 0;
        if (mode == 0) begin
            if (k == 10) begin
                mode = 1;
                digs.delete();
            end else if (k == 11) tok(2, 0);
            else if (k > 11) tok(3, 0);
        end else if (k <= 9) begin
            if (digs.size() == 4) begin
                tok(3, 0);
                mode = 0;
            end else digs.push_back(k);
        end else if (k == 10) begin
            if (digs.size() == 4) tok(1, bcd());
            else if (digs.size() == 3 && mode == 1) tok(0, bcd());
            else tok(3, 0);
            mode = 0;
        end else if (k == 11) begin
            if (digs.size() == 3 && mode == 1) begin
                tok(0, bcd());
                mode = 2;
                digs.delete();
            end else begin
                tok(3, 0);
                mode = 0;
            end
        end else begin
            tok(3, 0);
            mode = 0;
        end
    endfunction

    task automatic step(input int k);
        bus.key_in = 4'(k);
        @(posedge clk);
        model(k);
        @(negedge clk);
        check("valid", 32'(bus.tok_valid), 32'(m_valid));
        check("type", 32'(bus.tok_type), 32'(m_type));
        check("data", 32'(bus.tok_data), 32'(m_data));
    endtask

    task automatic play();
        foreach (seq[i]) step(seq[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(15);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.key_in = 4'hF;
        rst = 1'b1;
        model_reset();
        #5;
        check("rst_valid", 32'(bus.tok_valid), 32'd0);
        check("rst_type", 32'(bus.tok_type), 32'd0);
        check("rst_data", 32'(bus.tok_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Login frame then menu.
        seq = '{10, 0, 0, 1, 10, 11};
        play();
        // PIN frames, including a repeated digit.
        seq = '{10, 1, 2, 0, 2, 10, 10, 1, 1, 1, 1, 10};
        play();
        // Direct PIN after an M-closed ID.
        seq = '{10, 0, 0, 4, 11, 1, 2, 0, 2, 10};
        play();

        // Async reset mid-frame clears outputs between edges.
        seq = '{10, 0, 0};
        play();
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.tok_valid), 32'd0);
        check("arst_type", 32'(bus.tok_type), 32'd0);
        check("arst_data", 32'(bus.tok_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        seq = '{4, 10, 0, 0, 4, 10};
        play();

        // Entry errors.
        seq = '{10, 1, 2, 10, 10, 1, 2, 3, 4, 5};
        play();
        seq = '{10, 1, 12, 0, 0, 0, 14, 13};
        play();
        // Timeout expiry and just-short-of-expiry.
        seq = '{10, 1};
        play();
        idle(TIMEOUT);
        seq = '{10, 1};
        play();
        idle(TIMEOUT - 1);
        seq = '{2, 3, 10};
        play();
        seq = '{10, 0, 0, 4, 11, 1};
        play();
        idle(TIMEOUT + 2);

        // Random key streams with occasional long K runs.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 45) step(int'($urandom_range(0, 9)));
            else if (r < 62) step(10);
            else if (r < 68) step(11);
            else if (r < 71) step(int'($urandom_range(12, 14)));
            else if (r < 95) step(15);
            else idle(int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
